// File: rtl/uart_pkg.sv
// Shared constants, FSM encodings and sizing helper for the UART packet framer.
package uart_pkg;

  localparam int UART_BYTE_W   = 8;
  localparam int MAX_PKT_BYTES = 16;

  typedef enum logic [1:0] {
    R_IDLE    = 2'd0,
    R_COLLECT = 2'd1,
    R_HOLD    = 2'd2
  } rx_state_e;

  typedef enum logic [1:0] {
    T_IDLE  = 2'd0,
    T_START = 2'd1,
    T_WAIT  = 2'd2
  } tx_state_e;

  // Counter width able to hold 0..v-1, never narrower than one bit.
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/uart_packet_framer_if.sv
// Byte-side and packet-side handshake bundle of the UART packet framer.
interface uart_packet_framer_if #(
  parameter int PKT_BYTES = 2
);

  logic                                    rx_done;
  logic [uart_pkg::UART_BYTE_W-1:0]           rx_data;
  logic [PKT_BYTES*uart_pkg::UART_BYTE_W-1:0] pkt_data;
  logic                                    pkt_valid;
  logic                                    pkt_ready;
  logic [PKT_BYTES*uart_pkg::UART_BYTE_W-1:0] rsp_data;
  logic                                    rsp_valid;
  logic                                    rsp_ready;
  logic                                    tx_start;
  logic [uart_pkg::UART_BYTE_W-1:0]           tx_data;
  logic                                    tx_done;
  logic                                    tx_busy;
  logic                                    timeout_err;
  logic                                    overrun_err;

  // Framer side.
  modport slave (
    input  rx_done, rx_data, pkt_ready, rsp_data, rsp_valid, tx_done,
    output pkt_data, pkt_valid, rsp_ready, tx_start, tx_data, tx_busy,
           timeout_err, overrun_err
  );

  // Core / UART byte-engine side.
  modport master (
    output rx_done, rx_data, pkt_ready, rsp_data, rsp_valid, tx_done,
    input  pkt_data, pkt_valid, rsp_ready, tx_start, tx_data, tx_busy,
           timeout_err, overrun_err
  );

endinterface

// File: rtl/uart_pkt_serializer.sv
// Latches a response packet and hands it to UART_TX one byte at a time, byte 0 first.
module uart_pkt_serializer
  import uart_pkg::*;
#(
  parameter int PKT_BYTES = 2
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [PKT_BYTES*UART_BYTE_W-1:0]   rsp_data,
  input  logic                               rsp_valid,
  output logic                               rsp_ready,
  output logic                               tx_start,
  output logic [UART_BYTE_W-1:0]             tx_data,
  input  logic                               tx_done,
  output logic                               tx_busy
);

  localparam int              IDX_W    = clog2_min1(PKT_BYTES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_BYTES - 1);

  tx_state_e                             state, state_next;
  logic [IDX_W-1:0]                      idx;
  logic [PKT_BYTES-1:0][UART_BYTE_W-1:0] rsp_q;
  logic                                  accept, last_done;

  assign accept    = (state == T_IDLE) && rsp_valid;
  assign last_done = (state == T_WAIT) && tx_done && (idx == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= T_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      T_IDLE:  if (rsp_valid) state_next = T_START;
      T_START: state_next = T_WAIT;
      T_WAIT:  if (tx_done) state_next = (idx == LAST_IDX) ? T_IDLE : T_START;
      default: state_next = T_IDLE;
    endcase
  end

  always_comb begin
    rsp_ready = (state == T_IDLE);
    tx_busy   = (state != T_IDLE);
    tx_start  = (state == T_START);
    tx_data   = '0;
    for (int k = 0; k < PKT_BYTES; k++) begin
      if (idx == IDX_W'(k)) tx_data = rsp_q[k];
    end
  end

  // idx only advances on tx_done in T_WAIT, so tx_data holds from tx_start to tx_done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx   <= '0;
      rsp_q <= '0;
    end else if (accept) begin
      idx   <= '0;
      rsp_q <= rsp_data;
    end else if ((state == T_WAIT) && tx_done && !last_done) begin
      idx <= idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/uart_packet_framer.sv
// Packet layer between byte-level UART_RX/UART_TX and the core: RX assembly here, TX in the serializer.
module uart_packet_framer
  import uart_pkg::*;
#(
  parameter int PKT_BYTES      = 2,
  parameter int TIMEOUT_CYCLES = 104166
) (
  input logic                 clk,
  input logic                 rst_n,
  uart_packet_framer_if.slave bus
);

  localparam int               CNT_W    = clog2_min1(PKT_BYTES + 1);
  localparam int               TMR_W    = clog2_min1(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PKT_BYTES - 1);
  localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT_CYCLES);
  localparam bit               TMR_EN   = (TIMEOUT_CYCLES != 0);

  rx_state_e                             rx_state, rx_next;
  logic [CNT_W-1:0]                      cnt, wr_idx;
  logic [TMR_W-1:0]                      timer;
  logic [PKT_BYTES-1:0][UART_BYTE_W-1:0] pkt_q;
  logic                                  handshake, store, timeout_hit;

  // A byte arriving in R_HOLD is only kept when the held packet leaves in the same cycle.
  always_comb begin
    handshake   = (rx_state == R_HOLD) && bus.pkt_ready;
    store       = bus.rx_done && ((rx_state != R_HOLD) || bus.pkt_ready);
    wr_idx      = (rx_state == R_COLLECT) ? cnt : '0;
    timeout_hit = TMR_EN && (rx_state == R_COLLECT) && !bus.rx_done && (timer == TMR_MAX);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_state <= R_IDLE;
    else        rx_state <= rx_next;
  end

  // NOTE: the default assignment first keeps this combinational block from inferring a latch.
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      R_IDLE:
        if (bus.rx_done) rx_next = (PKT_BYTES == 1) ? R_HOLD : R_COLLECT;
      R_COLLECT:
        if (bus.rx_done && (cnt == LAST_IDX)) rx_next = R_HOLD;
        else if (timeout_hit)                 rx_next = R_IDLE;
      R_HOLD:
        if (handshake) rx_next = !bus.rx_done      ? R_IDLE :
                                 (PKT_BYTES == 1)  ? R_HOLD : R_COLLECT;
      default:
        rx_next = R_IDLE;
    endcase
  end

  always_comb begin
    bus.pkt_valid   = (rx_state == R_HOLD);
    bus.overrun_err = (rx_state == R_HOLD) && bus.rx_done && !bus.pkt_ready;
    bus.timeout_err = timeout_hit;
  end

  // NOTE: the packet buffer drives a port that must read 0 out of reset, so it is reset like control state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      timer <= '0;
      pkt_q <= '0;
    end else begin
      if (store)                         cnt <= wr_idx + CNT_W'(1);
      else if (timeout_hit || handshake) cnt <= '0;

      // The idle timer only runs between bytes of a partial packet and saturates at its limit.
      if ((rx_next != R_COLLECT) || bus.rx_done) timer <= '0;
      else if (timer != TMR_MAX)                 timer <= timer + TMR_W'(1);

      for (int k = 0; k < PKT_BYTES; k++) begin
        if (store && (wr_idx == CNT_W'(k))) pkt_q[k] <= bus.rx_data;
      end
    end
  end

  assign bus.pkt_data = pkt_q;

  uart_pkt_serializer #(
    .PKT_BYTES (PKT_BYTES)
  ) u_serializer (
    .clk       (clk),
    .rst_n     (rst_n),
    .rsp_data  (bus.rsp_data),
    .rsp_valid (bus.rsp_valid),
    .rsp_ready (bus.rsp_ready),
    .tx_start  (bus.tx_start),
    .tx_data   (bus.tx_data),
    .tx_done   (bus.tx_done),
    .tx_busy   (bus.tx_busy)
  );

endmodule

// File: tb/tb_uart_packet_framer.sv
// Directed bench: a 2-byte framer driven by hand plus a 4-byte framer wired as a loopback.
module tb_uart_packet_framer;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  uart_packet_framer_if #(.PKT_BYTES(2)) bus2 ();
  uart_packet_framer_if #(.PKT_BYTES(4)) bus4 ();

  uart_packet_framer #(.PKT_BYTES(2), .TIMEOUT_CYCLES(1000)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  uart_packet_framer #(.PKT_BYTES(4), .TIMEOUT_CYCLES(1000)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  // Loopback: the assembled packet is offered straight back as the response.
  assign bus4.rsp_data  = bus4.pkt_data;
  assign bus4.rsp_valid = bus4.pkt_valid;
  assign bus4.pkt_ready = bus4.rsp_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rx_byte(input bit sel4, input logic [7:0] b);
    if (sel4) begin bus4.rx_data = b; bus4.rx_done = 1'b1; end
    else      begin bus2.rx_data = b; bus2.rx_done = 1'b1; end
    tick();
    bus4.rx_done = 1'b0;
    bus2.rx_done = 1'b0;
  endtask

  task automatic handshake2();
    bus2.pkt_ready = 1'b1;
    tick();
    bus2.pkt_ready = 1'b0;
  endtask

  initial begin
    int  first_to;
    bit  pv_seen;
    int  starts;
    bit  found;

    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    bus2.rx_done = 1'b0; bus2.rx_data = '0; bus2.pkt_ready = 1'b0;
    bus2.rsp_data = '0;  bus2.rsp_valid = 1'b0; bus2.tx_done = 1'b0;
    bus4.rx_done = 1'b0; bus4.rx_data = '0; bus4.tx_done = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_pkt_valid", 32'(bus2.pkt_valid), 0);
    check("rst_pkt_data",  32'(bus2.pkt_data), 0);
    check("rst_rsp_ready", 32'(bus2.rsp_ready), 1);
    check("rst_tx_start",  32'(bus2.tx_start), 0);
    check("rst_tx_data",   32'(bus2.tx_data), 0);
    check("rst_tx_busy",   32'(bus2.tx_busy), 0);
    check("rst_timeout",   32'(bus2.timeout_err), 0);
    check("rst_overrun",   32'(bus2.overrun_err), 0);
    rst_n = 1'b1;
    tick();

    // 1. Two-byte packet, held, then released by handshake
    rx_byte(0, 8'hA5);
    bus2.rx_data = 8'h3C; bus2.rx_done = 1'b1;
    @(negedge clk);
    check("t1_valid_during_rx", 32'(bus2.pkt_valid), 0);
    tick();
    bus2.rx_done = 1'b0;
    @(negedge clk);
    check("t1_valid_after_rx", 32'(bus2.pkt_valid), 1);
    check("t1_data", 32'(bus2.pkt_data), 32'h3CA5);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t1_hold_valid", 32'(bus2.pkt_valid), 1);
      check("t1_hold_data", 32'(bus2.pkt_data), 32'h3CA5);
    end
    tick();
    handshake2();
    @(negedge clk);
    check("t1_valid_cleared", 32'(bus2.pkt_valid), 0);
    check("t1_data_kept", 32'(bus2.pkt_data), 32'h3CA5);

    // 2. Inter-byte timeout discards a partial packet
    tick();
    rx_byte(0, 8'h11);
    first_to = 0;
    pv_seen  = 1'b0;
    for (int c = 1; c <= 1200 && first_to == 0; c++) begin
      @(negedge clk);
      if (bus2.pkt_valid)   pv_seen  = 1'b1;
      if (bus2.timeout_err) first_to = c;
    end
    check("t2_timeout_near_1000", 32'(first_to >= 995 && first_to <= 1005), 1);
    check("t2_no_pkt_valid", 32'(pv_seen), 0);
    @(negedge clk);
    check("t2_timeout_pulse_width", 32'(bus2.timeout_err), 0);
    tick();
    rx_byte(0, 8'h01);
    rx_byte(0, 8'h02);
    @(negedge clk);
    check("t2_new_valid", 32'(bus2.pkt_valid), 1);
    check("t2_new_data", 32'(bus2.pkt_data), 32'h0201);
    tick();
    handshake2();

    // 3. Overrun while held, then byte taken during the handshake cycle
    rx_byte(0, 8'h55);
    rx_byte(0, 8'h66);
    bus2.rx_data = 8'h77; bus2.rx_done = 1'b1;
    @(negedge clk);
    check("t3_overrun_pulse", 32'(bus2.overrun_err), 1);
    tick();
    bus2.rx_done = 1'b0;
    @(negedge clk);
    check("t3_overrun_low", 32'(bus2.overrun_err), 0);
    check("t3_data_unchanged", 32'(bus2.pkt_data), 32'h6655);
    check("t3_still_valid", 32'(bus2.pkt_valid), 1);
    tick();
    bus2.rx_data = 8'h88; bus2.rx_done = 1'b1; bus2.pkt_ready = 1'b1;
    @(negedge clk);
    check("t3_no_overrun_on_hs", 32'(bus2.overrun_err), 0);
    tick();
    bus2.rx_done = 1'b0; bus2.pkt_ready = 1'b0;
    @(negedge clk);
    check("t3_valid_after_hs", 32'(bus2.pkt_valid), 0);
    check("t3_new_byte0_stale_byte1", 32'(bus2.pkt_data), 32'h6688);
    tick();
    rx_byte(0, 8'h99);
    @(negedge clk);
    check("t3_next_pkt", 32'(bus2.pkt_data), 32'h9988);
    check("t3_next_valid", 32'(bus2.pkt_valid), 1);
    tick();
    handshake2();

    // 4. Response serialisation
    bus2.rsp_data = 16'hBEEF; bus2.rsp_valid = 1'b1;
    @(negedge clk);
    check("t4_rsp_ready_idle", 32'(bus2.rsp_ready), 1);
    check("t4_no_start_yet", 32'(bus2.tx_start), 0);
    tick();
    bus2.rsp_valid = 1'b0;
    @(negedge clk);
    check("t4_start0", 32'(bus2.tx_start), 1);
    check("t4_data0", 32'(bus2.tx_data), 32'hEF);
    check("t4_busy", 32'(bus2.tx_busy), 1);
    check("t4_rsp_ready_low", 32'(bus2.rsp_ready), 0);
    tick();
    @(negedge clk);
    check("t4_start_one_cycle", 32'(bus2.tx_start), 0);
    check("t4_data0_stable", 32'(bus2.tx_data), 32'hEF);
    tick();
    bus2.tx_done = 1'b1;
    @(negedge clk);
    check("t4_no_start_on_done", 32'(bus2.tx_start), 0);
    tick();
    bus2.tx_done = 1'b0;
    @(negedge clk);
    check("t4_start1", 32'(bus2.tx_start), 1);
    check("t4_data1", 32'(bus2.tx_data), 32'hBE);
    tick();
    bus2.tx_done = 1'b1;
    tick();
    bus2.tx_done = 1'b0;
    @(negedge clk);
    check("t4_busy_done", 32'(bus2.tx_busy), 0);
    check("t4_rsp_ready_back", 32'(bus2.rsp_ready), 1);
    tick();
    bus2.tx_done = 1'b1;
    tick();
    bus2.tx_done = 1'b0;
    starts = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus2.tx_start) starts++;
    end
    check("t4_stray_done_ignored", 32'(starts), 0);

    // 5. Reset during T_WAIT
    tick();
    bus2.rsp_data = 16'h1234; bus2.rsp_valid = 1'b1;
    tick();
    bus2.rsp_valid = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_busy_rst", 32'(bus2.tx_busy), 0);
    check("t5_ready_rst", 32'(bus2.rsp_ready), 1);
    check("t5_start_rst", 32'(bus2.tx_start), 0);
    check("t5_txdata_rst", 32'(bus2.tx_data), 0);
    check("t5_pktdata_rst", 32'(bus2.pkt_data), 0);
    @(negedge clk);
    rst_n = 1'b1;
    starts = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus2.tx_start) starts++;
    end
    check("t5_no_start_after_rst", 32'(starts), 0);

    // 6. Four-byte loopback
    tick();
    for (int i = 1; i <= 4; i++) rx_byte(1, 8'(i));
    for (int i = 1; i <= 4; i++) begin
      found = 1'b0;
      for (int c = 0; c < 20 && !found; c++) begin
        @(negedge clk);
        if (bus4.tx_start) found = 1'b1;
      end
      check("t6_tx_start_seen", 32'(found), 1);
      check("t6_tx_byte", 32'(bus4.tx_data), 32'(i));
      tick();
      bus4.tx_done = 1'b1;
      tick();
      bus4.tx_done = 1'b0;
    end
    @(negedge clk);
    check("t6_busy_done", 32'(bus4.tx_busy), 0);
    check("t6_pkt_released", 32'(bus4.pkt_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
